// File: rtl/job_scheduler_pkg.sv
// Shared types for the job scheduler: controller states, completion status
// codes and the flag recording why the controller entered RECOVER.
package job_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    ABORT,
    RECOVER,
    REPORT
  } state_t;

  typedef enum logic {
    PATH_FAULT,
    PATH_TIMEOUT
  } path_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FAULT   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/job_scheduler_arbiter.sv
// Combinational round-robin pick: first set req bit scanning from rr_ptr
// upward, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr) + i >= N_REQ) ? ID_W'(int'(rr_ptr) + i - N_REQ)
                                         : ID_W'(int'(rr_ptr) + i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// Time-shares one start/abort worker between N_REQ requesters with a
// watchdog timeout, bounded retry on fault and per-job completion status.
module job_scheduler
  import job_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200,
  parameter int MAX_RETRY   = 2,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             cmpl_valid,
  output logic [ID_W-1:0]  cmpl_id,
  output logic [1:0]       cmpl_status,
  output logic             wk_start,
  output logic             wk_abort,
  input  logic             wk_busy,
  input  logic             wk_error,
  output logic             hang
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYC);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [ID_W-1:0]    ID_LAST    = ID_W'(N_REQ - 1);

  state_t             state, state_d;
  path_t              path, path_d;
  logic [ID_W-1:0]    cur_id, cur_id_d, rr_ptr, rr_ptr_d, arb_idx;
  logic               arb_any;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [RETRY_W-1:0] retry_cnt, retry_cnt_d;
  logic [1:0]         status_d;
  logic               hang_d, timer_expired;
  logic [N_REQ-1:0]   grant_d;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  assign timer_expired = (timer == TIMER_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state;
    path_d      = path;
    cur_id_d    = cur_id;
    rr_ptr_d    = rr_ptr;
    retry_cnt_d = retry_cnt;
    status_d    = ST_OK;
    hang_d      = hang;
    unique case (state)
      IDLE: if (arb_any) begin
        cur_id_d = arb_idx;
        state_d  = LAUNCH;
      end
      LAUNCH: begin
        if (wk_error) begin
          path_d  = PATH_FAULT;
          state_d = RECOVER;
        end else if (wk_busy)  state_d = RUN;
        else if (timer_expired) state_d = ABORT;
      end
      RUN: begin
        if (wk_error) begin
          path_d  = PATH_FAULT;
          state_d = RECOVER;
        end else if (!wk_busy) begin
          status_d = ST_OK;
          state_d  = REPORT;
        end else if (timer_expired) state_d = ABORT;
      end
      ABORT: begin
        if (wk_error) begin
          path_d  = PATH_TIMEOUT;
          state_d = RECOVER;
        end else if (timer_expired) begin
          // Worker ignored the abort for a full window: flag it permanently.
          hang_d   = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = REPORT;
        end
      end
      RECOVER: if (!wk_error && !wk_busy) begin
        if (path == PATH_TIMEOUT) begin
          status_d = ST_TIMEOUT;
          state_d  = REPORT;
        end else if (retry_cnt < RETRY_MAX) begin
          retry_cnt_d = retry_cnt + 1'b1;
          state_d     = LAUNCH;
        end else begin
          status_d = ST_FAULT;
          state_d  = REPORT;
        end
      end
      REPORT: begin
        rr_ptr_d    = (cur_id == ID_LAST) ? '0 : cur_id + 1'b1;
        retry_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts on entry to LAUNCH or ABORT and runs through LAUNCH+RUN.
  always_comb begin
    timer_d = timer;
    if ((state_d == LAUNCH && state != LAUNCH) || (state_d == ABORT && state != ABORT))
      timer_d = '0;
    else if ((state inside {LAUNCH, RUN, ABORT}) && timer != TIMER_MAX)
      timer_d = timer + 1'b1;
  end

  always_comb begin
    grant_d = '0;
    if (state_d inside {LAUNCH, RUN, ABORT, RECOVER}) grant_d[cur_id_d] = 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      path        <= PATH_FAULT;
      cur_id      <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      grant       <= '0;
      wk_start    <= 1'b0;
      wk_abort    <= 1'b0;
      cmpl_valid  <= 1'b0;
      cmpl_id     <= '0;
      cmpl_status <= ST_OK;
      hang        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      path       <= path_d;
      cur_id     <= cur_id_d;
      rr_ptr     <= rr_ptr_d;
      timer      <= timer_d;
      retry_cnt  <= retry_cnt_d;
      grant      <= grant_d;
      wk_start   <= (state_d == LAUNCH);
      wk_abort   <= (state_d == ABORT);
      cmpl_valid <= (state_d == REPORT);
      hang       <= hang_d;
      if (state_d == REPORT) begin
        cmpl_id     <= cur_id;
        cmpl_status <= status_d;
      end
    end
  end

endmodule

// File: doc/job_scheduler.md
Name: job_scheduler

Overview:
Time-shares one run/done/fault worker FSM between N_REQ requesters.
- Arbitrates pending requests round-robin and drives the worker's start and fault inputs.
- Watches the worker's busy/error outputs, applies a watchdog timeout and bounded retry on fault.
- Returns a per-job completion status to the granted requester.
- Sits between the requester ports and the worker, which is the only driver of busy/error.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 200, max cycles in LAUNCH+RUN (and in ABORT) before timeout
MAX_RETRY, 2, re-launches allowed after a worker fault
ID_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester
grant  out  N_REQ  one-hot; owner of the current job
cmpl_valid  out  1  one-cycle completion pulse
cmpl_id  out  ID_W  requester index of completed job
cmpl_status  out  2  0=OK, 1=FAULT, 2=TIMEOUT, 3=reserved
wk_start  out  1  to worker start input
wk_abort  out  1  to worker fault input
wk_busy  in  1  from worker busy output
wk_error  in  1  from worker error output
hang  out  1  sticky: worker ignored abort; cleared only by reset

Behaviour:
- Clock and reset: single clock, clk; reset is asynchronous, active-low, rst_n. All outputs are registered.
- Reset values: state=IDLE; grant, cmpl_valid, cmpl_id, cmpl_status, wk_start, wk_abort, hang all 0; rr_ptr=0; timer=0; retry_cnt=0.
- IDLE:
  - If any req bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ... mod N_REQ; latch it into cur_id.
  - Next cycle: grant[cur_id]=1, wk_start=1, timer=0, state LAUNCH.
- LAUNCH:
  - wk_start held at 1.
  - wk_busy=1 -> RUN; wk_start=0 from the next cycle. This lets the worker pass through DONE back to IDLE.
  - wk_error=1 -> RECOVER (fault path).
  - timer==TIMEOUT_CYC-1 -> ABORT.
- RUN:
  - Precedence: wk_error=1 -> RECOVER (fault path); else wk_busy=0 -> REPORT with status OK; else timer==TIMEOUT_CYC-1 -> ABORT.
- ABORT:
  - wk_abort=1 and timer restarts.
  - wk_error=1 -> wk_abort=0, RECOVER (timeout path).
  - Timer expires again -> hang=1, wk_abort=0, REPORT with status TIMEOUT.
- RECOVER:
  - Wait for wk_error=0 and wk_busy=0.
  - Timeout path -> REPORT TIMEOUT.
  - Fault path with retry_cnt<MAX_RETRY -> retry_cnt+1, timer=0, wk_start=1, LAUNCH with the same cur_id; grant stays asserted.
  - Otherwise -> REPORT FAULT.
- REPORT (one cycle):
  - cmpl_valid=1 with cmpl_id=cur_id and status; grant=0.
  - rr_ptr=(cur_id+1) mod N_REQ; retry_cnt=0; next state IDLE.
- Timer: width $clog2(TIMEOUT_CYC+1); saturates; counts only in LAUNCH, RUN and ABORT.
- Requests:
  - A requester drops req after seeing cmpl_valid with its id.
  - A req still high in IDLE is re-arbitrated; the rr_ptr advance guarantees other requesters are served first.
  - Deasserting req mid-job does not cancel the job.
  - Requests arriving mid-job wait.
- Outputs:
  - wk_start and wk_abort are never 1 in the same cycle.
  - grant is at most one-hot; it is 0 in IDLE.
- Reset mid-job: all outputs return to reset values immediately. wk_start=0 releases the worker; no completion is reported.

Decomposition:
- Package job_sched_pkg: state enum (IDLE, LAUNCH, RUN, ABORT, RECOVER, REPORT); status constants ST_OK=0, ST_FAULT=1, ST_TIMEOUT=2; path flag type (fault/timeout).
- Sub-module rr_arbiter: combinational round-robin pick. Inputs req and rr_ptr; outputs idx and any.

Test Plan:
- req=4'b0001, worker busy 5 cycles then done -> grant=0001; wk_start high until busy seen; cmpl_valid with id=0, status=0; rr_ptr=1.
- req=4'b1111 held, each job 3 cycles -> completion order id 0,1,2,3,0; no requester served twice before all others.
- Worker raises error once in RUN for id=2, then OK on relaunch -> one relaunch with grant held; cmpl status=0, id=2.
- Worker faults 3 times with MAX_RETRY=2 -> exactly 3 launches; cmpl status=1; next job starts only after wk_error=0.
- Busy stuck high, worker honours abort -> ABORT entered at cycle 200 of the job; wk_abort until error; cmpl status=2; hang=0.
- Busy stuck high, error never rises -> status=2 after a further 200 cycles; hang=1 and stays 1; rst_n low mid-job clears all outputs asynchronously.
